// File: rtl/pulse_counter_tx.sv
// Pulse edge counter feeding the SPI master TX start/data inputs, with wrap/saturate limit.
// Optional input debounce filter enabled by defining PULSE_COUNTER_TX_DEBOUNCE_EN.
module pulse_counter_tx #(
    parameter int DATAWIDTH_BUS   = 8,
    parameter int STATE_SIZE      = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     PULSE_COUNTER_TX_CLOCK_50,
    input  logic                     PULSE_COUNTER_TX_RESET_InHigh,
    input  logic                     PULSE_COUNTER_TX_COUNT_InHigh,
    input  logic                     PULSE_COUNTER_TX_masterBusy_InHigh,
    input  logic                     PULSE_COUNTER_TX_enable_InHigh,
    input  logic                     PULSE_COUNTER_TX_clear_InHigh,
    input  logic                     PULSE_COUNTER_TX_satMode_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] PULSE_COUNTER_TX_limit_In,
    output logic                     PULSE_COUNTER_TX_start_Out,
    output logic [DATAWIDTH_BUS-1:0] PULSE_COUNTER_TX_data_Out,
    output logic                     PULSE_COUNTER_TX_wrap_Out,
    output logic                     PULSE_COUNTER_TX_sat_Out,
    output logic                     PULSE_COUNTER_TX_miss_Out
);

    if (DATAWIDTH_BUS < 2 || STATE_SIZE < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("pulse_counter_tx: invalid parameter value");
    end

    typedef enum logic [STATE_SIZE-1:0] {
        IDLE  = 'd0,
        ARMED = 'd1,
        PEND  = 'd2,
        START = 'd3
    } state_t;

    state_t state;

    logic count_q1;
    logic count_q2;

`ifdef PULSE_COUNTER_TX_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic            count_sync;
    logic [DB_W-1:0] db_cnt;

    // q1 follows the synchronised input only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge PULSE_COUNTER_TX_CLOCK_50) begin
        if (PULSE_COUNTER_TX_RESET_InHigh) begin
            count_sync <= 1'b0;
            count_q1   <= 1'b0;
            db_cnt     <= '0;
        end else begin
            count_sync <= PULSE_COUNTER_TX_COUNT_InHigh;
            if (count_sync == count_q1) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                count_q1 <= count_sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
`else
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PULSE_COUNTER_TX_CLOCK_50) begin
        if (PULSE_COUNTER_TX_RESET_InHigh) count_q1 <= 1'b0;
        else                               count_q1 <= PULSE_COUNTER_TX_COUNT_InHigh;
    end
`endif

    always_ff @(posedge PULSE_COUNTER_TX_CLOCK_50) begin
        if (PULSE_COUNTER_TX_RESET_InHigh) count_q2 <= 1'b0;
        else                               count_q2 <= count_q1;
    end

    logic                     edge_raw;
    logic                     cnt_edge;
    logic                     at_limit;
    logic                     start_edge;
    logic [DATAWIDTH_BUS-1:0] data_inc;

    // Clear wins over a coincident edge; a saturated count raises no further start requests.
    assign edge_raw   = count_q1 & ~count_q2 & PULSE_COUNTER_TX_enable_InHigh;
    assign cnt_edge   = edge_raw & ~PULSE_COUNTER_TX_clear_InHigh;
    assign at_limit   = (PULSE_COUNTER_TX_data_Out >= PULSE_COUNTER_TX_limit_In);
    assign start_edge = cnt_edge & ~(PULSE_COUNTER_TX_satMode_InHigh & at_limit);
    assign data_inc   = PULSE_COUNTER_TX_data_Out + 1'b1;

    always_ff @(posedge PULSE_COUNTER_TX_CLOCK_50) begin
        if (PULSE_COUNTER_TX_RESET_InHigh) begin
            PULSE_COUNTER_TX_data_Out <= '0;
            PULSE_COUNTER_TX_wrap_Out <= 1'b0;
            PULSE_COUNTER_TX_sat_Out  <= 1'b0;
        end else begin
            PULSE_COUNTER_TX_wrap_Out <= 1'b0;
            if (PULSE_COUNTER_TX_clear_InHigh) begin
                PULSE_COUNTER_TX_data_Out <= '0;
                PULSE_COUNTER_TX_sat_Out  <= 1'b0;
            end else if (cnt_edge) begin
                if (!at_limit) begin
                    PULSE_COUNTER_TX_data_Out <= data_inc;
                    if (PULSE_COUNTER_TX_satMode_InHigh && data_inc == PULSE_COUNTER_TX_limit_In)
                        PULSE_COUNTER_TX_sat_Out <= 1'b1;
                end else if (PULSE_COUNTER_TX_satMode_InHigh) begin
                    PULSE_COUNTER_TX_data_Out <= PULSE_COUNTER_TX_limit_In;
                    PULSE_COUNTER_TX_sat_Out  <= 1'b1;
                end else begin
                    PULSE_COUNTER_TX_data_Out <= '0;
                    PULSE_COUNTER_TX_wrap_Out <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge PULSE_COUNTER_TX_CLOCK_50) begin
        if (PULSE_COUNTER_TX_RESET_InHigh) begin
            state                      <= IDLE;
            PULSE_COUNTER_TX_start_Out <= 1'b0;
            PULSE_COUNTER_TX_miss_Out  <= 1'b0;
        end else begin
            PULSE_COUNTER_TX_start_Out <= 1'b0;
            if (PULSE_COUNTER_TX_clear_InHigh) PULSE_COUNTER_TX_miss_Out <= 1'b0;

            if (!PULSE_COUNTER_TX_enable_InHigh) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (start_edge) begin
                            if (PULSE_COUNTER_TX_masterBusy_InHigh) begin
                                state <= PEND;
                            end else begin
                                state                      <= START;
                                PULSE_COUNTER_TX_start_Out <= 1'b1;
                            end
                        end
                    end
                    PEND: begin
                        if (start_edge) PULSE_COUNTER_TX_miss_Out <= 1'b1;
                        if (!PULSE_COUNTER_TX_masterBusy_InHigh) begin
                            state                      <= START;
                            PULSE_COUNTER_TX_start_Out <= 1'b1;
                        end
                    end
                    START: begin
                        if (start_edge && PULSE_COUNTER_TX_masterBusy_InHigh) begin
                            state <= PEND;
                        end else if (start_edge) begin
                            state                      <= START;
                            PULSE_COUNTER_TX_start_Out <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_counter_tx.sv
// Scoreboard bench for pulse_counter_tx: expected start/wrap events are queued by the
// stimulus and consumed by a monitor that watches the DUT outputs.
module tb_pulse_counter_tx;

    localparam int W = 8;
`ifdef PULSE_COUNTER_TX_DEBOUNCE_EN
    localparam int LAT = 6;
    localparam int PW  = 6;
    localparam int GAP = 8;
`else
    localparam int LAT = 2;
    localparam int PW  = 1;
    localparam int GAP = 3;
`endif

    typedef struct {
        logic [W-1:0] data;
        int           cycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         count_in = 1'b0;
    logic         busy = 1'b0;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic         sat_mode = 1'b0;
    logic [W-1:0] limit = 8'd10;
    logic         start;
    logic [W-1:0] data;
    logic         wrap;
    logic         sat;
    logic         miss;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t start_q[$];
    exp_t wrap_q[$];

    pulse_counter_tx #(.DATAWIDTH_BUS(W), .STATE_SIZE(3), .DEBOUNCE_CYCLES(4)) dut (
        .PULSE_COUNTER_TX_CLOCK_50         (clk),
        .PULSE_COUNTER_TX_RESET_InHigh     (rst),
        .PULSE_COUNTER_TX_COUNT_InHigh     (count_in),
        .PULSE_COUNTER_TX_masterBusy_InHigh(busy),
        .PULSE_COUNTER_TX_enable_InHigh    (enable),
        .PULSE_COUNTER_TX_clear_InHigh     (clear),
        .PULSE_COUNTER_TX_satMode_InHigh   (sat_mode),
        .PULSE_COUNTER_TX_limit_In         (limit),
        .PULSE_COUNTER_TX_start_Out        (start),
        .PULSE_COUNTER_TX_data_Out         (data),
        .PULSE_COUNTER_TX_wrap_Out         (wrap),
        .PULSE_COUNTER_TX_sat_Out          (sat),
        .PULSE_COUNTER_TX_miss_Out         (miss)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input pulse; optionally queue the start request it should produce.
    task automatic pulse(input bit exp_start, input logic [W-1:0] exp_data);
        if (exp_start) start_q.push_back('{exp_data, cyc + LAT});
        count_in = 1'b1;
        repeat (PW) tick();
        count_in = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Monitor: every start/wrap pulse must match the head of its queue.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            if (start_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                exp_t e;
                e = start_q.pop_front();
                check("start_data", int'(data), int'(e.data));
                check("start_cycle", cyc, e.cycle);
            end
        end
        if (wrap === 1'b1) begin
            if (wrap_q.size() == 0) begin
                check("unexpected_wrap", 1, 0);
            end else begin
                exp_t e;
                e = wrap_q.pop_front();
                check("wrap_data", int'(data), int'(e.data));
                check("wrap_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] exp_data1 [5];
        logic [W-1:0] exp_data3 [5];
        logic         exp_sat3  [5];
        exp_data1 = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        exp_data3 = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        exp_sat3  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (3) tick();
        check("reset_data", int'(data), 0);
        check("reset_start", int'(start), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_sat", int'(sat), 0);
        check("reset_miss", int'(miss), 0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // Basic counting with a start per edge
        for (int i = 1; i <= 3; i++) begin
            pulse(1'b1, W'(i));
            check("t1_data", int'(data), i);
        end

        // Wrap mode
        do_clear();
        check("t2_clear_data", int'(data), 0);
        limit = 8'd3;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) wrap_q.push_back('{8'd0, cyc + LAT});
            pulse(1'b1, exp_data1[i]);
            check("t2_data", int'(data), int'(exp_data1[i]));
        end

        // Saturate mode: starts only while the count is below the limit
        do_clear();
        sat_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse(i < 3, exp_data3[i]);
            check("t3_data", int'(data), int'(exp_data3[i]));
            check("t3_sat", int'(sat), int'(exp_sat3[i]));
        end
        do_clear();
        check("t3_clear_data", int'(data), 0);
        check("t3_clear_sat", int'(sat), 0);

        // Busy master: deferred start and missed edge
        sat_mode = 1'b0;
        limit = 8'd10;
        busy = 1'b1;
        pulse(1'b0, 8'd0);
        check("t4_data1", int'(data), 1);
        check("t4_miss1", int'(miss), 0);
        pulse(1'b0, 8'd0);
        check("t4_data2", int'(data), 2);
        check("t4_miss2", int'(miss), 1);
        start_q.push_back('{8'd2, cyc + 1});
        busy = 1'b0;
        repeat (3) tick();

        // Clear coincident with a detected edge
        count_in = 1'b1;
        repeat (LAT - 1) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        count_in = 1'b0;
        repeat (GAP) tick();
        check("t5_clear_edge_data", int'(data), 0);
        check("t5_clear_edge_miss", int'(miss), 0);

        // Disable while pending drops the start
        busy = 1'b1;
        pulse(1'b0, 8'd0);
        enable = 1'b0;
        tick();
        busy = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (2) tick();
        check("t5_disable_data", int'(data), 1);

        // Reset during START
        start_q.push_back('{8'd2, cyc + LAT});
        count_in = 1'b1;
        repeat (PW) tick();
        count_in = 1'b0;
        repeat (LAT - PW) tick();
        rst = 1'b1;
        tick();
        check("t5_rst_data", int'(data), 0);
        check("t5_rst_start", int'(start), 0);
        check("t5_rst_sat", int'(sat), 0);
        check("t5_rst_miss", int'(miss), 0);
        rst = 1'b0;
        repeat (6) tick();

`ifdef PULSE_COUNTER_TX_DEBOUNCE_EN
        // Short glitch is filtered, a long pulse counts once
        count_in = 1'b1;
        repeat (2) tick();
        count_in = 1'b0;
        repeat (10) tick();
        check("t6_glitch_data", int'(data), 0);
        pulse(1'b1, 8'd1);
        check("t6_pulse_data", int'(data), 1);
`endif

        repeat (4) tick();
        check("start_queue_empty", start_q.size(), 0);
        check("wrap_queue_empty", wrap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
